maze_seq_ctrl: RTL and testbench

MAZE_SEQ_CTRL -- requirements
Module: maze_seq_ctrl

---
 rtl/maze_pkg.sv | 17 +
 rtl/maze_row_mux.sv | 20 ++
 rtl/maze_seq_ctrl.sv | 113 +++++++++++
 tb/tb_maze_seq_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze sequencing controller.
package maze_pkg;
  localparam int MAZE_W_DEF = 16;
  localparam int MAZE_H_DEF = 16;
  localparam logic PATH = 1'b1;
  localparam logic WALL = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_GUARD  = 3'd2,
    S_CARVE  = 3'd3,
    S_SNAP   = 3'd4,
    S_STREAM = 3'd5,
    S_DONE   = 3'd6
  } state_t;
endpackage

// File: rtl/maze_row_mux.sv
// Combinational row select: returns snapshot row `sel` (bit x = column x).
module maze_row_mux #(
  parameter int MAZE_W = 16,
  parameter int MAZE_H = 16
) (
  input  logic [MAZE_W*MAZE_H-1:0] snap,
  input  logic [3:0]               sel,
  output logic [MAZE_W-1:0]        row
);
  logic [MAZE_H-1:0][MAZE_W-1:0] rows;

  for (genvar y = 0; y < MAZE_H; y++) begin : g_row
    assign rows[y] = snap[y*MAZE_W +: MAZE_W];
  end

  always_comb begin
    row = '0;
    if (int'(sel) < MAZE_H) row = rows[sel];
  end
endmodule

// File: rtl/maze_seq_ctrl.sv
// Sequences one carver run (arm, guard, carve with timeout), snapshots the
// bitmap and streams it row by row over a valid/ready handshake.
module maze_seq_ctrl
  import maze_pkg::*;
#(
  parameter int MAZE_W      = MAZE_W_DEF,
  parameter int MAZE_H      = MAZE_H_DEF,
  parameter int TIMEOUT_CYC = 65535,
  parameter int GUARD_CYC   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     gen_req,
  output logic                     carver_start,
  input  logic                     carver_finish,
  input  logic [MAZE_W*MAZE_H-1:0] maze_data,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic [MAZE_W-1:0]        row_data,
  output logic [3:0]               row_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC + 1) : 1;
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] G_LAST   = GW'(GUARD_CYC - 1);
  localparam logic [3:0]    LAST_ROW = 4'(MAZE_H - 1);

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [GW-1:0]            g_cnt;
  logic [3:0]               ptr;
  logic [MAZE_W*MAZE_H-1:0] snap;
  logic                     timed, tmo_hit;

  // A finish seen on the last allowed CARVE cycle still wins over the timeout.
  assign timed   = (state == S_ARM) || (state == S_GUARD) || (state == S_CARVE);
  assign tmo_hit = timed && (cnt == TO_LAST) && !(state == S_CARVE && carver_finish);
  assign row_idx = ptr;

  maze_row_mux #(.MAZE_W(MAZE_W), .MAZE_H(MAZE_H)) u_row_mux (
    .snap (snap),
    .sel  (ptr),
    .row  (row_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      carver_start <= 1'b0;
      row_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      cnt          <= '0;
      g_cnt        <= '0;
      ptr          <= '0;
      snap         <= {(MAZE_W*MAZE_H){WALL}};
    end else begin
      done <= 1'b0;
      if (timed) cnt <= cnt + 1'b1;
      if (tmo_hit) begin
        state        <= S_IDLE;
        carver_start <= 1'b0;
        busy         <= 1'b0;
        timeout_err  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (gen_req) begin
            state        <= S_ARM;
            carver_start <= 1'b1;
            busy         <= 1'b1;
            cnt          <= '0;
            timeout_err  <= 1'b0;
          end
          // Wait for a stale finish from the previous run to clear.
          S_ARM: if (!carver_finish) begin
            state        <= S_GUARD;
            carver_start <= 1'b0;
            g_cnt        <= '0;
          end
          S_GUARD: begin
            g_cnt <= g_cnt + 1'b1;
            if (g_cnt == G_LAST) state <= S_CARVE;
          end
          S_CARVE: if (carver_finish) state <= S_SNAP;
          S_SNAP: begin
            snap      <= maze_data;
            ptr       <= '0;
            row_valid <= 1'b1;
            state     <= S_STREAM;
          end
          S_STREAM: if (row_ready) begin
            if (ptr == LAST_ROW) begin
              row_valid <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_maze_seq_ctrl.sv
// Directed bench for maze_seq_ctrl: nominal, backpressure, timeout, stale finish,
// snapshot isolation and mid-stream reset.
module tb_maze_seq_ctrl;
  logic         clk, rst, gen_req, carver_start, carver_finish;
  logic [255:0] maze_data;
  logic         row_valid, row_ready, busy, done, timeout_err;
  logic [15:0]  row_data;
  logic [3:0]   row_idx;
  int           n_cmp = 0;
  int           n_err = 0;
  logic [255:0] p0, p1, p2, p3;

  maze_seq_ctrl #(.MAZE_W(16), .MAZE_H(16), .TIMEOUT_CYC(100), .GUARD_CYC(2)) dut (
    .clk(clk), .rst(rst), .gen_req(gen_req), .carver_start(carver_start),
    .carver_finish(carver_finish), .maze_data(maze_data), .row_valid(row_valid),
    .row_ready(row_ready), .row_data(row_data), .row_idx(row_idx), .busy(busy),
    .done(done), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk(input logic [15:0] seed);
    logic [255:0] m;
    for (int y = 0; y < 16; y++)
      m[y*16 +: 16] = seed ^ 16'((y + 1) * 16'h1357) ^ 16'(y << 8);
    return m;
  endfunction

  // Carver model: finish drops one cycle after start, rises 20 cycles after start falls.
  task automatic run_carver();
    gen_req = 1'b1;
    tick();
    gen_req = 1'b0;
    chk("arm_start", carver_start, 1);
    chk("arm_busy", busy, 1);
    carver_finish = 1'b0;
    tick();
    chk("guard_start", carver_start, 0);
    repeat (19) tick();
    carver_finish = 1'b1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 64 && row_valid !== 1'b1; i++) tick();
    chk("wait_valid", row_valid, 1);
  endtask

  task automatic stream(input logic [255:0] m, input logic [15:0] stall, input int nrows);
    row_ready = 1'b1;
    for (int y = 0; y < nrows; y++) begin
      if (stall[y]) begin
        row_ready = 1'b0;
        repeat (3) begin
          chk("hold_valid", row_valid, 1);
          chk("hold_idx", row_idx, y);
          chk("hold_data", row_data, m[y*16 +: 16]);
          tick();
        end
        row_ready = 1'b1;
      end
      chk("row_valid", row_valid, 1);
      chk("row_idx", row_idx, y);
      chk("row_data", row_data, m[y*16 +: 16]);
      chk("early_done", done, 0);
      tick();
    end
    if (nrows == 16) begin
      chk("done_pulse", done, 1);
      chk("done_novalid", row_valid, 0);
      tick();
      chk("done_once", done, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    p0 = mk(16'hA5C3);
    p1 = mk(16'h0F0F);
    p2 = mk(16'h8421);
    p3 = mk(16'h7E18);
    rst = 1'b1; gen_req = 1'b0; carver_finish = 1'b1; row_ready = 1'b0; maze_data = p0;
    tick(); tick();
    chk("rst_start", carver_start, 0);
    chk("rst_valid", row_valid, 0);
    chk("rst_data", row_data, 0);
    chk("rst_idx", row_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", timeout_err, 0);
    rst = 1'b0;
    tick();

    // nominal
    run_carver();
    wait_valid();
    stream(p0, 16'h0000, 16);

    // backpressure on rows 0, 7, 15
    maze_data = p1;
    run_carver();
    wait_valid();
    stream(p1, 16'h8081, 16);

    // timeout: finish never rises
    carver_finish = 1'b0;
    gen_req = 1'b1;
    tick();
    gen_req = 1'b0;
    repeat (99) begin
      chk("to_novalid", row_valid, 0);
      tick();
    end
    chk("to_busy_pre", busy, 1);
    chk("to_err_pre", timeout_err, 0);
    tick();
    chk("to_busy", busy, 0);
    chk("to_err", timeout_err, 1);
    chk("to_start", carver_start, 0);
    chk("to_valid", row_valid, 0);

    // stale finish held for 5 ARM cycles, finish pulse inside GUARD
    carver_finish = 1'b1;
    maze_data = p2;
    gen_req = 1'b1;
    tick();
    gen_req = 1'b0;
    chk("err_clear", timeout_err, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stale_start", carver_start, 1);
      if (i == 4) carver_finish = 1'b0;
      tick();
    end
    chk("stale_start_off", carver_start, 0);
    carver_finish = 1'b1;
    tick();
    chk("guard_start2", carver_start, 0);
    tick();
    carver_finish = 1'b0;
    tick(); tick();
    chk("guard_ignored", row_valid, 0);
    chk("guard_busy", busy, 1);
    carver_finish = 1'b1;
    wait_valid();
    // snapshot isolation
    maze_data = '1;
    stream(p2, 16'h0000, 16);

    // reset mid-stream after row 5, with gen_req asserted alongside
    maze_data = p3;
    run_carver();
    wait_valid();
    stream(p3, 16'h0000, 6);
    rst = 1'b1;
    gen_req = 1'b1;
    tick();
    chk("mrst_valid", row_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_idx", row_idx, 0);
    chk("mrst_data", row_data, 0);
    chk("mrst_start", carver_start, 0);
    rst = 1'b0;
    gen_req = 1'b0;
    tick();
    chk("mrst_nodone", done, 0);
    chk("mrst_idle", busy, 0);
    run_carver();
    wait_valid();
    stream(p3, 16'h0000, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
